// File: rtl/vga_line_pingpong_buffer_if.sv
// rtl/vga_line_pingpong_buffer_if.sv - pixel write stream from the SDRAM reader into the line buffer
interface vga_line_pingpong_buffer_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/vga_line_pingpong_buffer.sv
// rtl/vga_line_pingpong_buffer.sv - two-bank ping-pong VGA line buffer with replication and underrun tracking
module vga_line_pingpong_buffer #(
    parameter int PIX_W    = 8,
    parameter int LINE_LEN = 640,
    parameter int ADDR_W   = 10,
    parameter int PIX_DUP  = 1,
    parameter int UCNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_en,
    input  logic                      line_start,
    input  logic                      active,
    input  logic [ADDR_W-1:0]         x,
    output logic [PIX_W-1:0]          pix_out,
    output logic                      pix_valid,
    vga_line_pingpong_buffer_if.slave wr,
    output logic                      fill_req,
    output logic                      underrun,
    output logic [UCNT_W-1:0]         underrun_cnt,
    input  logic                      underrun_clr
);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(LINE_LEN - 1);
    localparam logic [ADDR_W:0]   LINE_LEN_W = (ADDR_W + 1)'(LINE_LEN);

    typedef enum logic {FILL, FULL} fill_state_t;

    fill_state_t       state, state_nxt;
    logic              fill_bank, disp_bank, disp_ok;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_ready_q;
    logic              start_pend;
    logic              accept, last_beat, swap;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_in_range;
    logic [PIX_W-1:0]  rd_q;
    logic              rd_vld;

    // Both banks live in one array; the bank select is the address MSB.
    logic [PIX_W-1:0] mem [0:(2**(ADDR_W+1))-1];

    assign wr.wr_ready = wr_ready_q;
    assign pix_out     = rd_vld ? rd_q : '0;
    assign pix_valid   = rd_vld;

    // Handshake decode and fill FSM next state; a last beat landing with line_start still counts as complete.
    always_comb begin
        accept      = wr.wr_valid && wr_ready_q;
        last_beat   = accept && (wr_ptr == LAST_IDX);
        swap        = line_start && ((state == FULL) || last_beat);
        state_nxt   = state;
        rd_addr     = (PIX_DUP == 2) ? (x >> 1) : x;
        rd_in_range = ({1'b0, rd_addr} < LINE_LEN_W);
        if (swap) begin
            state_nxt = FILL;
        end else if (last_beat) begin
            state_nxt = FULL;
        end
    end

    // Fill FSM state, bank selection, write pointer and fill request pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            fill_bank  <= 1'b0;
            disp_bank  <= 1'b1;
            wr_ptr     <= '0;
            disp_ok    <= 1'b0;
            wr_ready_q <= 1'b0;
            start_pend <= 1'b1;
            fill_req   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ready_q <= (state_nxt == FILL);
            start_pend <= 1'b0;
            fill_req   <= start_pend || swap;
            if (swap) begin
                disp_bank <= fill_bank;
                fill_bank <= ~fill_bank;
                wr_ptr    <= '0;
                disp_ok   <= 1'b1;
            end else if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Sticky underrun flag and saturating counter; a clear beats a coincident underrun.
    always_ff @(posedge clk) begin
        if (reset || underrun_clr) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (line_start && !swap) begin
            underrun <= 1'b1;
            if (underrun_cnt != '1) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
        end
    end

    // Write port into the bank being filled.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[{fill_bank, wr_ptr}] <= wr.wr_data;
        end
    end

    // Registered read port, kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (pix_en) begin
            rd_q <= mem[{disp_bank, rd_addr}];
        end
    end

    // Pixel qualifier, sampled on the same strobe as the read; it masks pix_out when low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld <= 1'b0;
        end else if (pix_en) begin
            rd_vld <= active && disp_ok && rd_in_range;
        end
    end
endmodule
